// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_pkg;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 1 << AW;

    // Writeback source; also the encoding of the arbiter's last-grant state.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback requests, issue/query scoreboard access and register-file write port.
interface regfile_wb_scheduler_if;
    import regfile_pkg::*;

    logic          alu_valid;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          alu_ready;

    logic          mem_valid;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          mem_ready;

    logic          issue_valid;
    logic [AW-1:0] issue_reg;
    logic [AW-1:0] query_reg_1;
    logic [AW-1:0] query_reg_2;
    logic          busy_1;
    logic          busy_2;

    logic          RegWrite;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;

    // Pipeline side: drives requests and queries.
    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output mem_valid, mem_reg, mem_data,
        input  mem_ready,
        output issue_valid, issue_reg, query_reg_1, query_reg_2,
        input  busy_1, busy_2,
        input  RegWrite, write_register, write_data
    );

    // Scheduler side.
    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  mem_valid, mem_reg, mem_data,
        output mem_ready,
        input  issue_valid, issue_reg, query_reg_1, query_reg_2,
        output busy_1, busy_2,
        output RegWrite, write_register, write_data
    );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is the ALU, req[1]/gnt[1] the load path.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_e last_q;
    src_e last_d;

    // Last-grant register; reset to MEM so the ALU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= SRC_MEM;
        end else begin
            last_q <= last_d;
        end
    end

    // Grant: a lone requester wins, a tie goes to the source not granted last.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_q == SRC_MEM) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Last-grant follows every grant; idle cycles leave it alone.
    always_comb begin
        last_d = last_q;
        if (gnt[0]) begin
            last_d = SRC_ALU;
        end else if (gnt[1]) begin
            last_d = SRC_MEM;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and load writeback and keeps
// a busy scoreboard of registers with a pending write.
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    regfile_wb_scheduler_if.slave bus
);

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            xfer;
    logic            commit;
    logic [AW-1:0]   xfer_reg;
    logic [DW-1:0]   xfer_data;

    logic            reg_write_q;
    logic [AW-1:0]   wr_reg_q;
    logic [DW-1:0]   wr_data_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    assign req = {bus.mem_valid, bus.alu_valid};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign bus.alu_ready = gnt[0];
    assign bus.mem_ready = gnt[1];

    // Select the granted request; writes to register 0 are accepted but dropped.
    always_comb begin
        xfer      = |gnt;
        xfer_reg  = gnt[1] ? bus.mem_reg  : bus.alu_reg;
        xfer_data = gnt[1] ? bus.mem_data : bus.alu_data;
        commit    = xfer && (xfer_reg != REG_ZERO);
    end

    // Register-file write port; index and data hold when nothing commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            reg_write_q <= commit;
            if (commit) begin
                wr_reg_q  <= xfer_reg;
                wr_data_q <= xfer_data;
            end
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so a newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (commit) begin
            busy_d[xfer_reg] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_reg != REG_ZERO)) begin
            busy_d[bus.issue_reg] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.busy_1         = (bus.query_reg_1 != REG_ZERO) && busy_q[bus.query_reg_1];
    assign bus.busy_2         = (bus.query_reg_2 != REG_ZERO) && busy_q[bus.query_reg_2];
    assign bus.RegWrite       = reg_write_q;
    assign bus.write_register = wr_reg_q;
    assign bus.write_data     = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler.
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_reg     = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_reg     = '0;
        bus.mem_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_reg   = '0;
        bus.query_reg_1 = '0;
        bus.query_reg_2 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst = 1'b1;
        // ready must stay low during reset even with a request present
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd5;
        tick();
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("rst_wr_reg", 32'(bus.write_register), 32'd0);
        check("rst_wr_data", bus.write_data, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single ALU writeback, one-cycle latency
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("t1_mem_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        bus.alu_valid = 1'b0;
        check("t1_regwrite", 32'(bus.RegWrite), 32'd1);
        check("t1_wr_reg", 32'(bus.write_register), 32'd5);
        check("t1_wr_data", bus.write_data, 32'hDEADBEEF);
        tick();
        check("t1_regwrite_off", 32'(bus.RegWrite), 32'd0);
        check("t1_wr_reg_hold", 32'(bus.write_register), 32'd5);

        // Tie after reset: ALU then MEM, then lone ALU
        do_reset();
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd3;
        bus.alu_data  = 32'h11;
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd4;
        bus.mem_data  = 32'h22;
        #1;
        check("t2_c0_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("t2_c0_mem_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        check("t2_c1_wr_reg", 32'(bus.write_register), 32'd3);
        check("t2_c1_wr_data", bus.write_data, 32'h11);
        check("t2_c1_alu_ready", 32'(bus.alu_ready), 32'd0);
        check("t2_c1_mem_ready", 32'(bus.mem_ready), 32'd1);
        tick();
        bus.mem_valid = 1'b0;
        check("t2_c2_regwrite", 32'(bus.RegWrite), 32'd1);
        check("t2_c2_wr_reg", 32'(bus.write_register), 32'd4);
        check("t2_c2_wr_data", bus.write_data, 32'h22);
        #1;
        check("t2_c2_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        bus.alu_valid = 1'b0;
        check("t2_c3_wr_reg", 32'(bus.write_register), 32'd3);

        // Scoreboard set by issue, cleared by load writeback edge
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd7;
        bus.query_reg_1 = 5'd7;
        #1;
        check("t3_busy_before", 32'(bus.busy_1), 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        check("t3_busy_set", 32'(bus.busy_1), 32'd1);
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd7;
        bus.mem_data  = 32'h77;
        #1;
        check("t3_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("t3_busy_xfer_cycle", 32'(bus.busy_1), 32'd1);
        tick();
        bus.mem_valid = 1'b0;
        check("t3_busy_cleared", 32'(bus.busy_1), 32'd0);
        check("t3_wr_reg", 32'(bus.write_register), 32'd7);

        // Simultaneous set and clear of reg 9: set wins
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd9;
        bus.query_reg_2 = 5'd9;
        tick();
        check("t4_busy_set", 32'(bus.busy_2), 32'd1);
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd9;
        bus.alu_data  = 32'h99;
        #1;
        check("t4_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b0;
        check("t4_busy_kept", 32'(bus.busy_2), 32'd1);
        check("t4_wr_reg", 32'(bus.write_register), 32'd9);
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd9;
        bus.mem_data  = 32'h98;
        tick();
        bus.mem_valid = 1'b0;
        check("t4_busy_cleared", 32'(bus.busy_2), 32'd0);

        // Register 0: accepted, never written, never busy
        bus.alu_valid   = 1'b1;
        bus.alu_reg     = 5'd0;
        bus.alu_data    = 32'hFFFFFFFF;
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd0;
        bus.query_reg_1 = 5'd0;
        #1;
        check("t5_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        bus.alu_valid   = 1'b0;
        bus.issue_valid = 1'b0;
        check("t5_regwrite", 32'(bus.RegWrite), 32'd0);
        check("t5_busy_r0", 32'(bus.busy_1), 32'd0);

        // Async reset mid-cycle while a load to busy reg 12 is pending
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd12;
        bus.query_reg_1 = 5'd12;
        bus.alu_valid   = 1'b1;
        bus.alu_reg     = 5'd13;
        bus.alu_data    = 32'h13;
        tick();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b0;
        check("t6_regwrite_pre", 32'(bus.RegWrite), 32'd1);
        check("t6_busy_pre", 32'(bus.busy_1), 32'd1);
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd12;
        bus.mem_data  = 32'hC;
        #2;
        rst = 1'b1;
        #1;
        check("t6_regwrite_rst", 32'(bus.RegWrite), 32'd0);
        check("t6_busy_rst", 32'(bus.busy_1), 32'd0);
        check("t6_mem_ready_rst", 32'(bus.mem_ready), 32'd0);
        bus.mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t6_regwrite_after", 32'(bus.RegWrite), 32'd0);
        check("t6_wr_reg_after", 32'(bus.write_register), 32'd0);
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd1;
        bus.alu_data  = 32'hA1;
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd2;
        bus.mem_data  = 32'hB2;
        #1;
        check("t6_tie_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("t6_tie_mem_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        idle_inputs();
        check("t6_tie_wr_reg", 32'(bus.write_register), 32'd1);
        check("t6_tie_wr_data", bus.write_data, 32'hA1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port (RegWrite / write_register / write_data) between two writeback requesters: ALU and memory-load.
- Tracks in-flight destination registers in a busy scoreboard so issue logic can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file, and drives the register file's write port directly.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register index width (log2 NREG).
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_reg  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  load writeback request.
- mem_reg  in  AW  load destination register.
- mem_data  in  DW  load data.
- mem_ready  out  1  load request granted this cycle.
- issue_valid  in  1  instruction issued that will write a register.
- issue_reg  in  AW  its destination register.
- query_reg_1  in  AW  source register 1 of the instruction being issued.
- query_reg_2  in  AW  source register 2 of the instruction being issued.
- busy_1  out  1  query_reg_1 has a pending write.
- busy_2  out  1  query_reg_2 has a pending write.
- RegWrite  out  1  register-file write enable.
- write_register  out  AW  register-file write index.
- write_data  out  DW  register-file write data.

Behaviour:
- Reset (async, rst=1): RegWrite=0, write_register=0, write_data=0, busy vector all 0, last_grant=MEM.
  - While rst is high, alu_ready=0 and mem_ready=0.
  - Reset mid-transfer drops any accepted but uncommitted write.
- Handshake:
  - A transfer occurs when valid && ready.
  - ready is combinational from the valid inputs and last_grant; it never depends on data.
  - A requester holds valid, reg and data stable until ready.
  - At most one ready is high per cycle.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the source not granted last; last_grant updates on every transfer.
  - After reset, ALU wins the first tie.
  - Neither valid: no grant, last_grant unchanged.
- Latency: the edge after a transfer registers RegWrite=1, write_register=reg, write_data=data. One cycle; outputs are registered.
  - With no transfer, RegWrite=0 next cycle; write_register and write_data hold their previous values.
- Register 0:
  - A transfer with reg=0 is accepted (ready=1) but produces RegWrite=0 and does not touch the scoreboard.
  - issue_reg=0 never sets busy; busy_1/busy_2 for query 0 are always 0.
- Scoreboard: busy[NREG-1:0].
  - Set on issue_valid && issue_reg!=0.
  - Cleared on the edge that commits the write (transfer edge) for that reg.
  - Simultaneous set and clear of the same reg: set wins (a newer producer is pending).
  - Issue to an already-busy reg: stays busy.
  - A writeback to a non-busy reg still writes, with no scoreboard error.
- Bypass: busy_1 and busy_2 are combinational from the current busy vector.
  - A register whose clearing transfer happens this cycle still reads busy=1; it is 0 the following cycle.
  - The register file's write is visible to readers in the cycle RegWrite is high.
- Widths: no arithmetic; reg indices are used directly. NREG must equal 2^AW.

Decomposition:
- Shared package regfile_pkg holds:
  - AW, DW, NREG constants.
  - Source enum {SRC_ALU=0, SRC_MEM=1} used for last_grant.
  - Constant REG_ZERO=0.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with last-grant state, clk/rst, req[1:0] in, gnt[1:0] out.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset, then alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF one cycle -> alu_ready=1 that cycle; next cycle RegWrite=1, write_register=5, write_data=0xDEADBEEF; following cycle RegWrite=0.
- Both valid after reset (alu_reg=3 data 0x11, mem_reg=4 data 0x22, held) -> cycle0 ALU granted, cycle1 MEM granted; writes to 3 then 4 on consecutive cycles; no cycle with both ready high.
- issue_valid reg=7; query_reg_1=7 -> busy_1=1 next cycle; mem writeback reg=7 -> busy_1 stays 1 in the transfer cycle, 0 the cycle after.
- Same cycle: issue_valid reg=9 and ALU transfer to reg=9 with 9 already busy -> busy[9] remains 1.
- ALU transfer reg=0 data 0xFFFFFFFF -> alu_ready=1, RegWrite stays 0; issue_reg=0 -> busy_1 for query 0 stays 0.
- Assert rst asynchronously (mid-clock) while mem transfer reg=12 is pending and busy[12]=1 -> RegWrite=0 immediately, busy all clear, no write to 12 after rst deasserts; next tie goes to ALU.
